// File: rtl/cell_win_pkg.sv
// Shared definitions for the cell window engine: FSM encoding, image
// geometry and the window-origin table that drives the sequential ALU.
package cell_win_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int IMG_DIM = 4;
    localparam int N_PIX   = 16;
    localparam int N_CELLS = 8;
    localparam int N_SUM   = 4;

    typedef enum logic {
        OP_SUM3 = 1'b0,
        OP_MAX2 = 1'b1
    } win_op_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        win_op_t    op;
    } win_origin_t;

    // Window table: indices 0..3 are the overlapping 3x3 sums,
    // 4..7 the non-overlapping 2x2 max-pool blocks, both in 11,12,21,22 order.
    function automatic win_origin_t win_origin(input logic [2:0] idx);
        win_origin_t o;
        case (idx)
            3'd0:    o = '{row: 2'd0, col: 2'd0, op: OP_SUM3};
            3'd1:    o = '{row: 2'd0, col: 2'd1, op: OP_SUM3};
            3'd2:    o = '{row: 2'd1, col: 2'd0, op: OP_SUM3};
            3'd3:    o = '{row: 2'd1, col: 2'd1, op: OP_SUM3};
            3'd4:    o = '{row: 2'd0, col: 2'd0, op: OP_MAX2};
            3'd5:    o = '{row: 2'd0, col: 2'd2, op: OP_MAX2};
            3'd6:    o = '{row: 2'd2, col: 2'd0, op: OP_MAX2};
            default: o = '{row: 2'd2, col: 2'd2, op: OP_MAX2};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cell_window_engine_if.sv
// Pixel stream and frame control bundle between a producer (master)
// and the cell window engine (slave).
interface cell_window_engine_if #(
    parameter int PIX_W = 4
) ();
    logic             start;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, busy, done
    );

    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, busy, done
    );
endinterface

// File: rtl/cell_window_alu.sv
// Combinational window evaluator: given the full 16-pixel store and a
// window index, produces the 8-bit result for that window.
// Build option: CELL_SAT_EN makes 3x3 sums saturate at 255 instead of
// wrapping modulo 256.
module cell_window_alu
    import cell_win_pkg::*;
#(
    parameter int PIX_W = 4
) (
    input  logic [PIX_W-1:0] pix [N_PIX],
    input  logic [2:0]       win_idx,
    output logic [7:0]       result
);

    localparam int SUM_W = PIX_W + 4;

    win_origin_t      org;
    logic [SUM_W-1:0] sum;
    logic [PIX_W-1:0] mx;
    logic [3:0]       a_sum;
    logic [3:0]       a_max;
    logic [7:0]       sum8;

    // Evaluate both operations from the window origin and pick by op type
    always_comb begin
        org   = win_origin(win_idx);
        sum   = '0;
        mx    = '0;
        a_sum = '0;
        a_max = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a_sum = {2'(org.row + 2'(i)), 2'(org.col + 2'(j))};
                sum   = sum + SUM_W'(pix[a_sum]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                a_max = {2'(org.row + 2'(i)), 2'(org.col + 2'(j))};
                if (pix[a_max] > mx) begin
                    mx = pix[a_max];
                end
            end
        end
`ifdef CELL_SAT_EN
        sum8 = (12'(sum) > 12'd255) ? 8'd255 : 8'(sum);
`else
        sum8 = 8'(sum);
`endif
        result = (org.op == OP_MAX2) ? 8'(mx) : sum8;
    end

endmodule

// File: rtl/cell_window_engine.sv
// Cell window engine: loads a 4x4 image over a valid/ready stream, then
// evaluates eight windows one per cycle into shadow registers and commits
// all eight outputs at once so the display never sees a partial frame.
// Build option: CELL_SAT_EN (3x3 sums saturate instead of truncating).
module cell_window_engine
    import cell_win_pkg::*;
#(
    parameter int PIX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cell_window_engine_if.slave     bus,
    output logic [7:0]              cell_3x3_11,
    output logic [7:0]              cell_3x3_12,
    output logic [7:0]              cell_3x3_21,
    output logic [7:0]              cell_3x3_22,
    output logic [7:0]              cell_2x2_11,
    output logic [7:0]              cell_2x2_12,
    output logic [7:0]              cell_2x2_21,
    output logic [7:0]              cell_2x2_22
);

    state_t           state_reg;
    logic [3:0]       pix_idx_reg;
    logic [2:0]       win_idx_reg;
    logic             pix_ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [7:0]       shadow_reg [N_CELLS];
    logic [7:0]       out_reg    [N_CELLS];
    logic [PIX_W-1:0] pix_word   [N_PIX];
    logic [7:0]       alu_result;
    logic             accept;

    assign accept = (state_reg == LOAD) && pix_ready_reg && bus.pix_valid;

    // Pixel store: one register per raster position, written on accept
    genvar gi;
    generate
        for (gi = 0; gi < N_PIX; gi++) begin : g_pix
            logic [PIX_W-1:0] px_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    px_reg <= '0;
                end else if (accept && (pix_idx_reg == 4'(gi))) begin
                    px_reg <= bus.pix_data;
                end
            end
            assign pix_word[gi] = px_reg;
        end
    endgenerate

    cell_window_alu #(
        .PIX_W (PIX_W)
    ) u_alu (
        .pix     (pix_word),
        .win_idx (win_idx_reg),
        .result  (alu_result)
    );

    // Frame sequencer with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pix_idx_reg   <= '0;
            win_idx_reg   <= '0;
            pix_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg     <= LOAD;
                        pix_idx_reg   <= '0;
                        pix_ready_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        pix_idx_reg <= pix_idx_reg + 4'd1;
                        if (pix_idx_reg == 4'(N_PIX - 1)) begin
                            state_reg     <= CALC;
                            pix_ready_reg <= 1'b0;
                            win_idx_reg   <= '0;
                        end
                    end
                end
                CALC: begin
                    win_idx_reg <= win_idx_reg + 3'd1;
                    if (win_idx_reg == 3'(N_CELLS - 1)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Shadow capture per window, then a single commit of all eight outputs;
    // the last window bypasses its shadow so it lands in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CELLS; k++) begin
                shadow_reg[k] <= '0;
                out_reg[k]    <= '0;
            end
        end else if (state_reg == CALC) begin
            shadow_reg[win_idx_reg] <= alu_result;
            if (win_idx_reg == 3'(N_CELLS - 1)) begin
                for (int k = 0; k < N_CELLS - 1; k++) begin
                    out_reg[k] <= shadow_reg[k];
                end
                out_reg[N_CELLS-1] <= alu_result;
            end
        end
    end

    assign bus.pix_ready = pix_ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

    assign cell_3x3_11 = out_reg[0];
    assign cell_3x3_12 = out_reg[1];
    assign cell_3x3_21 = out_reg[2];
    assign cell_3x3_22 = out_reg[3];
    assign cell_2x2_11 = out_reg[4];
    assign cell_2x2_12 = out_reg[5];
    assign cell_2x2_21 = out_reg[6];
    assign cell_2x2_22 = out_reg[7];

endmodule

// File: tb/tb_cell_window_engine.sv
// Directed bench for cell_window_engine: a PIX_W=4 instance for the
// functional scenarios and a PIX_W=5 instance for the width/reduction case.
module tb_cell_window_engine;
    import cell_win_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cell_window_engine_if #(.PIX_W(4)) if4 ();
    cell_window_engine_if #(.PIX_W(5)) if5 ();

    logic [7:0] c4 [8];
    logic [7:0] c5 [8];

    cell_window_engine #(.PIX_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(if4),
        .cell_3x3_11(c4[0]), .cell_3x3_12(c4[1]), .cell_3x3_21(c4[2]), .cell_3x3_22(c4[3]),
        .cell_2x2_11(c4[4]), .cell_2x2_12(c4[5]), .cell_2x2_21(c4[6]), .cell_2x2_22(c4[7])
    );

    cell_window_engine #(.PIX_W(5)) dut5 (
        .clk(clk), .rst(rst), .bus(if5),
        .cell_3x3_11(c5[0]), .cell_3x3_12(c5[1]), .cell_3x3_21(c5[2]), .cell_3x3_22(c5[3]),
        .cell_2x2_11(c5[4]), .cell_2x2_12(c5[5]), .cell_2x2_21(c5[6]), .cell_2x2_22(c5[7])
    );

    logic [7:0] exp_zero [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] exp_ramp [8] = '{8'd45, 8'd54, 8'd81, 8'd90, 8'd5, 8'd7, 8'd13, 8'd15};
    logic [7:0] exp_f15  [8] = '{8'd135, 8'd135, 8'd135, 8'd135, 8'd15, 8'd15, 8'd15, 8'd15};

    function automatic int pix_val(input int mode, input int cval, input int p);
        return (mode == 0) ? p : cval;
    endfunction

    // Drives one frame into dut4. start is raised together with pix_valid to
    // exercise the start-wins rule. lat = cycles from the 16th accept to done
    // (or the abort cycle when rst_at fires), -1 on timeout.
    task automatic run_frame(input int mode, input int cval, input bit gaps,
                             input int start_at, input int rst_at,
                             input logic [7:0] exp_old [8],
                             output int lat, output int hold_bad, output int idx_bad);
        int p;
        int guard;
        bit rdy;
        bit v;
        hold_bad = 0;
        idx_bad  = 0;
        lat      = -1;
        if4.start     = 1'b1;
        if4.pix_valid = 1'b1;
        if4.pix_data  = 4'(pix_val(mode, cval, 0));
        @(posedge clk); #1;
        if4.start = 1'b0;
        p = 0;
        guard = 0;
        while (p < 16 && guard < 400) begin
            v = !(gaps && ($urandom_range(0, 2) == 0));
            if4.pix_valid = v;
            if4.pix_data  = 4'(pix_val(mode, cval, p));
            rdy = if4.pix_ready;
            for (int k = 0; k < 8; k++) if (c4[k] !== exp_old[k]) hold_bad++;
            if (!v && dut4.pix_idx_reg !== 4'(p)) idx_bad++;
            @(posedge clk); #1;
            if (v && rdy) p++;
            guard++;
        end
        if4.pix_valid = 1'b0;
        if (p < 16) return;
        lat = 1;
        while (if4.done !== 1'b1 && lat < 40) begin
            for (int k = 0; k < 8; k++) if (c4[k] !== exp_old[k]) hold_bad++;
            if (lat == start_at) if4.start = 1'b1;
            if (lat == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if4.start = 1'b0;
            lat++;
        end
        if (lat >= 40) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (if4.busy !== 1'b0 || if4.pix_ready !== 1'b0 || if4.done !== 1'b0) begin
            bad++; $display("FAIL por_status: got busy=%b ready=%b done=%b expected 0 0 0", if4.busy, if4.pix_ready, if4.done);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (c4[k] !== 8'd0) begin
                bad++; $display("FAIL por_cell%0d: got %0d expected 0", k, c4[k]);
            end
        end
        rst = 1'b0;
        // pix_valid without start must not open the stream
        if4.pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if4.pix_valid = 1'b0;
        total++; if (if4.pix_ready !== 1'b0 || if4.busy !== 1'b0) begin
            bad++; $display("FAIL idle_valid: got ready=%b busy=%b expected 0 0", if4.pix_ready, if4.busy);
        end
        // mid-LOAD reset
        if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        if4.pix_valid = 1'b1;
        if4.pix_data = 4'd9;
        repeat (5) @(posedge clk);
        #1;
        if4.pix_valid = 1'b0;
        total++; if (if4.busy !== 1'b1 || if4.pix_ready !== 1'b1) begin
            bad++; $display("FAIL load_status: got busy=%b ready=%b expected 1 1", if4.busy, if4.pix_ready);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (if4.busy !== 1'b0 || if4.pix_ready !== 1'b0 || if4.done !== 1'b0) begin
            bad++; $display("FAIL rst_status: got busy=%b ready=%b done=%b expected 0 0 0", if4.busy, if4.pix_ready, if4.done);
        end
        total++; if (dut4.state_reg !== IDLE) begin
            bad++; $display("FAIL rst_state: got %0d expected %0d", dut4.state_reg, IDLE);
        end
        total++; if (dut4.pix_idx_reg !== 4'd0) begin
            bad++; $display("FAIL rst_pix_idx: got %0d expected 0", dut4.pix_idx_reg);
        end
        $display("reset: checked power-on and mid-LOAD reset");
    endtask

    task automatic test_ramp();
        int lat, hb, ib;
        run_frame(0, 0, 1'b0, -1, -1, exp_zero, lat, hb, ib);
        total++; if (lat !== 9) begin
            bad++; $display("FAIL ramp_latency: got %0d expected 9", lat);
        end
        total++; if (hb !== 0) begin
            bad++; $display("FAIL ramp_hold: got %0d early changes expected 0", hb);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (c4[k] !== exp_ramp[k]) begin
                bad++; $display("FAIL ramp_cell%0d: got %0d expected %0d", k, c4[k], exp_ramp[k]);
            end
        end
        @(posedge clk); #1;
        total++; if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
            bad++; $display("FAIL ramp_after_done: got done=%b busy=%b expected 0 0", if4.done, if4.busy);
        end
        $display("ramp: latency=%0d cells=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d", lat, c4[0], c4[1], c4[2], c4[3], c4[4], c4[5], c4[6], c4[7]);
    endtask

    task automatic test_stalls();
        int lat, hb, ib;
        run_frame(0, 0, 1'b1, -1, -1, exp_ramp, lat, hb, ib);
        total++; if (lat !== 9) begin
            bad++; $display("FAIL stall_latency: got %0d expected 9", lat);
        end
        total++; if (ib !== 0) begin
            bad++; $display("FAIL stall_idx_frozen: got %0d moves expected 0", ib);
        end
        total++; if (hb !== 0) begin
            bad++; $display("FAIL stall_hold: got %0d early changes expected 0", hb);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (c4[k] !== exp_ramp[k]) begin
                bad++; $display("FAIL stall_cell%0d: got %0d expected %0d", k, c4[k], exp_ramp[k]);
            end
        end
        @(posedge clk); #1;
        $display("stalls: latency=%0d idx_moves=%0d", lat, ib);
    endtask

    task automatic test_hold();
        int lat, hb, ib;
        run_frame(1, 15, 1'b0, 3, -1, exp_ramp, lat, hb, ib);
        total++; if (lat !== 9) begin
            bad++; $display("FAIL hold_latency: got %0d expected 9", lat);
        end
        total++; if (hb !== 0) begin
            bad++; $display("FAIL hold_old_values: got %0d early changes expected 0", hb);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (c4[k] !== exp_f15[k]) begin
                bad++; $display("FAIL hold_cell%0d: got %0d expected %0d", k, c4[k], exp_f15[k]);
            end
        end
        @(posedge clk); #1;
        total++; if (if4.busy !== 1'b0 || if4.pix_ready !== 1'b0) begin
            bad++; $display("FAIL hold_start_ignored: got busy=%b ready=%b expected 0 0", if4.busy, if4.pix_ready);
        end
        $display("hold: latency=%0d early_changes=%0d", lat, hb);
    endtask

    task automatic test_abort();
        int lat, hb, ib;
        run_frame(0, 0, 1'b0, -1, 4, exp_f15, lat, hb, ib);
        total++; if (lat !== 4) begin
            bad++; $display("FAIL abort_reached: got %0d expected 4", lat);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (c4[k] !== 8'd0) begin
                bad++; $display("FAIL abort_cell%0d: got %0d expected 0", k, c4[k]);
            end
        end
        total++; if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            bad++; $display("FAIL abort_status: got busy=%b done=%b expected 0 0", if4.busy, if4.done);
        end
        run_frame(0, 0, 1'b0, -1, -1, exp_zero, lat, hb, ib);
        total++; if (lat !== 9) begin
            bad++; $display("FAIL abort_relatency: got %0d expected 9", lat);
        end
        total++; if (hb !== 0) begin
            bad++; $display("FAIL abort_hold_zero: got %0d early changes expected 0", hb);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (c4[k] !== exp_ramp[k]) begin
                bad++; $display("FAIL abort_cell_new%0d: got %0d expected %0d", k, c4[k], exp_ramp[k]);
            end
        end
        @(posedge clk); #1;
        $display("abort: recovered frame latency=%0d", lat);
    endtask

    task automatic test_width();
        logic [7:0] exp_sum;
        int n;
        int guard;
`ifdef CELL_SAT_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd23;
`endif
        if5.start = 1'b1;
        @(posedge clk); #1;
        if5.start = 1'b0;
        if5.pix_valid = 1'b1;
        if5.pix_data = 5'd31;
        n = 0;
        guard = 0;
        while (n < 16 && guard < 100) begin
            if (if5.pix_ready === 1'b1) n++;
            @(posedge clk); #1;
            guard++;
        end
        if5.pix_valid = 1'b0;
        guard = 0;
        while (if5.done !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        total++; if (if5.done !== 1'b1) begin
            bad++; $display("FAIL width_done: got %b expected 1", if5.done);
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (c5[k] !== exp_sum) begin
                bad++; $display("FAIL width_sum%0d: got %0d expected %0d", k, c5[k], exp_sum);
            end
            total++; if (c5[k+4] !== 8'd31) begin
                bad++; $display("FAIL width_max%0d: got %0d expected 31", k, c5[k+4]);
            end
        end
        @(posedge clk); #1;
        $display("width: PIX_W=5 sums=%0d max=%0d", c5[0], c5[4]);
    endtask

    initial begin
        if4.start = 1'b0; if4.pix_valid = 1'b0; if4.pix_data = '0;
        if5.start = 1'b0; if5.pix_valid = 1'b0; if5.pix_data = '0;
        test_reset();
        test_ramp();
        test_stalls();
        test_hold();
        test_abort();
        test_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
